ring_decoder4bit: RTL and testbench
===================================

RING_DECODER4BIT -- requirements
Module: ring_decoder4bit

Interface
REQ-001 SHALL provide parameter: LOCK_CNT, default 4, number of consecutive correct ring steps required to declare lock (range 2..15).
REQ-002 SHALL provide port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL provide port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL provide port: ring_in  input  4  ring-counter code under observation.
REQ-005 SHALL provide port: sample_en  input  1  qualifies ring_in; one sample is taken per cycle where high.
REQ-006 SHALL provide port: index  output  2  binary position of the set bit of the last legal sample (bit0 -> 0 .. bit3 -> 3).
REQ-007 SHALL provide port: onehot_ok  output  1  last sample had exactly one bit set.
REQ-008 SHALL provide port: locked  output  1  decoder is in LOCKED state.
REQ-009 SHALL provide port: step_err  output  1  one-cycle pulse on any sequence fault while locked.
REQ-010 SHALL provide port: err_count  output  8  saturating count of step_err pulses.

Function
REQ-011 SHALL ignore ring_in and hold all state and outputs on cycles where sample_en is low.
REQ-012 SHALL classify a sample as legal iff exactly one of ring_in[3:0] is 1; 0000 and multi-bit values are illegal.
REQ-013 SHALL define the expected next sample as rotate-left of the previous legal sample: {prev[2:0], prev[3]} (1000 -> 0001 wrap).
REQ-014 SHALL register all outputs; index, onehot_ok, locked and step_err reflect a sample in the cycle after the sampling edge (latency 1).
REQ-015 SHALL leave index unchanged on an illegal sample and update it on every legal sample.
REQ-016 SHALL implement states SEARCH, TRACK, LOCKED with a good-step counter good_cnt (4 bits).
REQ-017 SEARCH: legal sample -> TRACK, good_cnt=0; illegal -> stay SEARCH.
REQ-018 TRACK: sample equal to expected -> good_cnt+1; when the increment reaches LOCK_CNT -> LOCKED on that edge.
REQ-019 TRACK: legal but unexpected sample (incl. repeat of previous) -> stay TRACK, good_cnt=0, new sample becomes reference; illegal -> SEARCH.
REQ-020 LOCKED: expected sample -> stay LOCKED, no pulse.
REQ-021 LOCKED: legal unexpected sample -> step_err=1 for one cycle, -> TRACK with good_cnt=0; illegal sample -> step_err=1, -> SEARCH.
REQ-022 SHALL assert step_err only from LOCKED; faults in SEARCH/TRACK SHALL NOT pulse or count.
REQ-023 SHALL increment err_count by 1 per step_err pulse and hold at 255 (no wrap).
REQ-024 SHALL deassert locked on the same edge that raises step_err.

Reset
REQ-025 SHALL, while reset is high, immediately force state=SEARCH, good_cnt=0, reference=0000, index=0, onehot_ok=0, locked=0, step_err=0, err_count=0, regardless of clk.
REQ-026 SHALL treat reset mid-lock or mid-pulse identically: lock, pending pulse and err_count are cleared; the first sample after release enters via SEARCH.

Structure
REQ-027 SHALL place the state enum (SEARCH, TRACK, LOCKED), RING_W=4 and ERR_CNT_W=8 in shared package ring_pkg.
REQ-028 SHALL isolate the combinational one-hot legality check and index encode in sub-module ring_onehot_enc (ring_in -> legal, idx).
REQ-029 SHALL be synthesizable with no latches and one always block per register group clocked on clk with async reset.

Verification
REQ-030 Lock: reset 20 ns, then sample_en=1 with 0001,0010,0100,1000,0001 -> locked=1 the cycle after the 5th sample (LOCK_CNT=4), index tracks 0,1,2,3,0.
REQ-031 Wrap: locked, feed 1000 then 0001 -> no step_err, index 3 -> 0.
REQ-032 Skip fault: locked at 0010, feed 1000 -> step_err one cycle, err_count=1, locked=0, state TRACK; then 0001,0010,0100,1000 -> relock.
REQ-033 Illegal code: locked, feed 0110 then 0000 -> one step_err (first only), onehot_ok=0, index held, state SEARCH, err_count+1.
REQ-034 Gating/saturation: sample_en low with toggling ring_in -> no output change; force 300 lock/fault cycles -> err_count stays 255.
REQ-035 Async reset: assert reset between clk edges while locked with err_count=5 -> all outputs 0 before next edge.

Source files
------------

// File: rtl/ring_pkg.sv
// Shared types and widths for the ring-counter decoder.
package ring_pkg;

    localparam int RING_W    = 4;
    localparam int ERR_CNT_W = 8;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } ring_state_e;

    // Next code a healthy ring counter should present after 'prev'.
    function automatic logic [RING_W-1:0] ring_next(input logic [RING_W-1:0] prev);
        return {prev[RING_W-2:0], prev[RING_W-1]};
    endfunction

endpackage

// File: rtl/ring_onehot_enc.sv
// Combinational legality check (exactly one bit set) and binary encode of the set bit.
module ring_onehot_enc
    import ring_pkg::*;
(
    input  logic [RING_W-1:0] ring_in,
    output logic              legal,
    output logic [1:0]        idx
);

    always_comb begin
        legal = 1'b1;
        idx   = 2'd0;
        case (ring_in)
            4'b0001: idx = 2'd0;
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/ring_decoder4bit.sv
// Ring-counter sequence monitor: tracks a rotating one-hot code, declares lock
// after LOCK_CNT correct steps and pulses/counts sequence faults while locked.
module ring_decoder4bit
    import ring_pkg::*;
#(
    parameter int LOCK_CNT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [RING_W-1:0]    ring_in,
    input  logic                 sample_en,
    output logic [1:0]           index,
    output logic                 onehot_ok,
    output logic                 locked,
    output logic                 step_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam logic [3:0]           LOCK_TGT = 4'(LOCK_CNT);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX  = '1;

    logic              legal;
    logic [1:0]        enc_idx;

    ring_state_e       state_q, state_d;
    logic [3:0]        good_cnt_q, good_cnt_d;
    logic [RING_W-1:0] ref_q, ref_d;
    logic              fault;

    logic [1:0]           index_q, index_d;
    logic                 onehot_ok_q, onehot_ok_d;
    logic                 locked_q, locked_d;
    logic                 step_err_q, step_err_d;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

    ring_onehot_enc u_enc (
        .ring_in (ring_in),
        .legal   (legal),
        .idx     (enc_idx)
    );

    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        ref_d      = ref_q;
        fault      = 1'b0;
        if (sample_en) begin
            case (state_q)
                SEARCH: begin
                    if (legal) begin
                        state_d    = TRACK;
                        good_cnt_d = 4'd0;
                        ref_d      = ring_in;
                    end
                end
                TRACK: begin
                    if (!legal) begin
                        state_d    = SEARCH;
                        good_cnt_d = 4'd0;
                    end else if (ring_in == ring_next(ref_q)) begin
                        good_cnt_d = good_cnt_q + 4'd1;
                        ref_d      = ring_in;
                        if (good_cnt_q + 4'd1 == LOCK_TGT)
                            state_d = LOCKED;
                    end else begin
                        // Unexpected but legal: restart the count from this code.
                        good_cnt_d = 4'd0;
                        ref_d      = ring_in;
                    end
                end
                LOCKED: begin
                    if (!legal) begin
                        fault      = 1'b1;
                        state_d    = SEARCH;
                        good_cnt_d = 4'd0;
                    end else if (ring_in == ring_next(ref_q)) begin
                        ref_d = ring_in;
                    end else begin
                        fault      = 1'b1;
                        state_d    = TRACK;
                        good_cnt_d = 4'd0;
                        ref_d      = ring_in;
                    end
                end
                default: begin
                    state_d    = SEARCH;
                    good_cnt_d = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= SEARCH;
            good_cnt_q <= 4'd0;
            ref_q      <= '0;
        end else begin
            state_q    <= state_d;
            good_cnt_q <= good_cnt_d;
            ref_q      <= ref_d;
        end
    end

    // step_err is a true one-cycle pulse; the other outputs hold when not sampling.
    always_comb begin
        index_d     = (sample_en && legal) ? enc_idx : index_q;
        onehot_ok_d = sample_en ? legal : onehot_ok_q;
        locked_d    = (state_d == LOCKED);
        step_err_d  = fault;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            index_q     <= 2'd0;
            onehot_ok_q <= 1'b0;
            locked_q    <= 1'b0;
            step_err_q  <= 1'b0;
        end else begin
            index_q     <= index_d;
            onehot_ok_q <= onehot_ok_d;
            locked_q    <= locked_d;
            step_err_q  <= step_err_d;
        end
    end

    always_comb begin
        err_count_d = err_count_q;
        if (fault && err_count_q != ERR_MAX)
            err_count_d = err_count_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            err_count_q <= '0;
        else
            err_count_q <= err_count_d;
    end

    assign index     = index_q;
    assign onehot_ok = onehot_ok_q;
    assign locked    = locked_q;
    assign step_err  = step_err_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_ring_decoder4bit.sv
// Directed bench for ring_decoder4bit with hand-computed expectations.
module tb_ring_decoder4bit;

    logic       clk;
    logic       reset;
    logic [3:0] ring_in;
    logic       sample_en;
    logic [1:0] index;
    logic       onehot_ok;
    logic       locked;
    logic       step_err;
    logic [7:0] err_count;

    int total = 0;
    int bad   = 0;

    ring_decoder4bit #(.LOCK_CNT(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .ring_in   (ring_in),
        .sample_en (sample_en),
        .index     (index),
        .onehot_ok (onehot_ok),
        .locked    (locked),
        .step_err  (step_err),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of stimulus, return #1 after the sampling edge.
    task automatic step(input logic [3:0] v, input logic en);
        ring_in   = v;
        sample_en = en;
        @(posedge clk);
        #1;
    endtask

    task automatic lock_seq();
        step(4'b0001, 1'b1);
        step(4'b0010, 1'b1);
        step(4'b0100, 1'b1);
        step(4'b1000, 1'b1);
        step(4'b0001, 1'b1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_idx"}, 32'(index), 0);
        chk({tag, "_ok"},  32'(onehot_ok), 0);
        chk({tag, "_lk"},  32'(locked), 0);
        chk({tag, "_se"},  32'(step_err), 0);
        chk({tag, "_ec"},  32'(err_count), 0);
    endtask

    initial begin
        reset     = 1'b1;
        ring_in   = 4'b0000;
        sample_en = 1'b0;
        #20;
        chk_all_zero("rst");
        @(negedge clk);
        reset = 1'b0;
        #1;

        // Lock sequence
        step(4'b0001, 1'b1); chk("l1_idx", 32'(index), 0); chk("l1_ok", 32'(onehot_ok), 1); chk("l1_lk", 32'(locked), 0);
        step(4'b0010, 1'b1); chk("l2_idx", 32'(index), 1);
        step(4'b0100, 1'b1); chk("l3_idx", 32'(index), 2);
        step(4'b1000, 1'b1); chk("l4_idx", 32'(index), 3); chk("l4_lk", 32'(locked), 0);
        step(4'b0001, 1'b1); chk("l5_idx", 32'(index), 0); chk("l5_lk", 32'(locked), 1);

        // Wrap 1000 -> 0001 while locked
        step(4'b0010, 1'b1);
        step(4'b0100, 1'b1);
        step(4'b1000, 1'b1); chk("w1_idx", 32'(index), 3); chk("w1_se", 32'(step_err), 0); chk("w1_lk", 32'(locked), 1);
        step(4'b0001, 1'b1); chk("w2_idx", 32'(index), 0); chk("w2_se", 32'(step_err), 0); chk("w2_lk", 32'(locked), 1);

        // Skip fault at 0010 -> 1000
        step(4'b0010, 1'b1);
        step(4'b1000, 1'b1); chk("s1_se", 32'(step_err), 1); chk("s1_ec", 32'(err_count), 1); chk("s1_lk", 32'(locked), 0);
        step(4'b0001, 1'b1); chk("s2_se", 32'(step_err), 0); chk("s2_lk", 32'(locked), 0);
        step(4'b0010, 1'b1);
        step(4'b0100, 1'b1); chk("s4_lk", 32'(locked), 0);
        step(4'b1000, 1'b1); chk("s5_lk", 32'(locked), 1); chk("s5_ec", 32'(err_count), 1);

        // Illegal codes while locked: only the first one faults
        step(4'b0110, 1'b1); chk("i1_se", 32'(step_err), 1); chk("i1_ok", 32'(onehot_ok), 0);
        chk("i1_idx", 32'(index), 3); chk("i1_lk", 32'(locked), 0); chk("i1_ec", 32'(err_count), 2);
        step(4'b0000, 1'b1); chk("i2_se", 32'(step_err), 0); chk("i2_ok", 32'(onehot_ok), 0);
        chk("i2_idx", 32'(index), 3); chk("i2_ec", 32'(err_count), 2);
        // From SEARCH: one entry sample plus four good steps
        step(4'b0100, 1'b1); chk("i3_idx", 32'(index), 2);
        step(4'b1000, 1'b1);
        step(4'b0001, 1'b1);
        step(4'b0010, 1'b1); chk("i6_lk", 32'(locked), 0);
        step(4'b0100, 1'b1); chk("i7_lk", 32'(locked), 1);

        // Gating: sample_en low, ring_in toggling
        step(4'b1111, 1'b0); chk("g1_idx", 32'(index), 2); chk("g1_ok", 32'(onehot_ok), 1); chk("g1_lk", 32'(locked), 1);
        step(4'b0000, 1'b0); chk("g2_ok", 32'(onehot_ok), 1); chk("g2_se", 32'(step_err), 0);
        step(4'b0001, 1'b0); chk("g3_idx", 32'(index), 2); chk("g3_ec", 32'(err_count), 2);
        step(4'b1000, 1'b1); chk("g4_lk", 32'(locked), 1); chk("g4_se", 32'(step_err), 0); chk("g4_idx", 32'(index), 3);

        // Saturation: 300 lock/fault rounds from err_count=2
        for (int i = 0; i < 300; i++) begin
            lock_seq();
            step(4'b0000, 1'b1);
        end
        chk("sat_se", 32'(step_err), 1);
        chk("sat_ec", 32'(err_count), 255);
        lock_seq();
        step(4'b0000, 1'b1);
        chk("sat2_ec", 32'(err_count), 255);

        // Async reset while locked with err_count=5
        @(negedge clk);
        reset = 1'b1;
        #2;
        chk_all_zero("r2");
        @(negedge clk);
        reset = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            lock_seq();
            step(4'b0000, 1'b1);
        end
        lock_seq();
        chk("a_lk", 32'(locked), 1);
        chk("a_ec", 32'(err_count), 5);
        #2;
        reset = 1'b1;
        #1;
        chk_all_zero("ar");
        @(negedge clk);
        reset = 1'b0;
        #1;
        // After release the first sample must enter via SEARCH
        step(4'b0010, 1'b1); chk("p1_idx", 32'(index), 1); chk("p1_lk", 32'(locked), 0);
        step(4'b0100, 1'b1);
        step(4'b1000, 1'b1);
        step(4'b0001, 1'b1); chk("p4_lk", 32'(locked), 0);
        step(4'b0010, 1'b1); chk("p5_lk", 32'(locked), 1); chk("p5_ec", 32'(err_count), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
